// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/memory-access port arbiter: FSM states,
// port owner encoding and default bus widths.
package mem_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } owner_t;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Priority decision between the fetch and memory-access requesters.
// On a tie the requester that was not granted last wins.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   if_req,
  input  logic   ma_req,
  input  owner_t last_owner,
  output owner_t winner
);

  always_comb begin
    winner = OWN_IF;
    if (if_req && ma_req) begin
      winner = (last_owner == OWN_IF) ? OWN_MA : OWN_IF;
    end else if (ma_req) begin
      winner = OWN_MA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch (IF) and memory-access (MA)
// stages. Optional ARB_ROUND_ROBIN_EN alternates ties; default is MA priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ma_req,
  input  logic              ma_we,
  input  logic [ADDR_W-1:0] ma_addr,
  input  logic [DATA_W-1:0] ma_wdata,
  output logic              ma_gnt,
  output logic              ma_rvalid,
  output logic [DATA_W-1:0] ma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
);

  state_t            r_state;
  state_t            w_state_nxt;
  owner_t            r_owner;
  owner_t            w_winner;
  owner_t            w_last_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              w_any_req;
  logic              w_grant;
  logic              w_resp;

  assign w_any_req = if_req | ma_req;

  // r_owner is loaded on every grant, so it doubles as the last-granted
  // record for round-robin ties; fixed priority feeds a constant instead.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_last_owner = r_owner;
`else
  assign w_last_owner = OWN_IF;
`endif

  arb_pick u_arb_pick (
    .if_req     (if_req),
    .ma_req     (ma_req),
    .last_owner (w_last_owner),
    .winner     (w_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ACCESS: w_state_nxt = RESP;
      default: begin
        w_grant     = w_any_req & ~rst;
        w_state_nxt = w_any_req ? ACCESS : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= 1'b0;
      if (w_grant) begin
        r_owner <= w_winner;
        if (w_winner == OWN_MA) begin
          r_mem_addr  <= ma_addr;
          r_mem_wdata <= ma_wdata;
          r_mem_we    <= ma_we;
        end else begin
          r_mem_addr <= if_addr;
        end
      end
    end
  end

  assign w_resp    = (r_state == RESP) & ~rst;
  assign if_gnt    = w_grant & (w_winner == OWN_IF);
  assign ma_gnt    = w_grant & (w_winner == OWN_MA);
  assign if_rvalid = w_resp & (r_owner == OWN_IF);
  assign ma_rvalid = w_resp & (r_owner == OWN_MA);
  assign if_rdata  = mem_rdata;
  assign ma_rdata  = mem_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign stall_if  = if_req & ~if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and a response scoreboard against a bench-side memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ma_req = 1'b0, ma_we = 1'b0;
  logic [15:0] if_addr = '0, ma_addr = '0, ma_wdata = '0;
  logic        if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_we, stall_if;
  logic [15:0] if_rdata, ma_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid), .ma_rdata(ma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // rmem is the memory the DUT talks to; mmem is what the bench expects it to hold
  logic [15:0] rmem [0:1023];
  logic [15:0] mmem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) begin
      rmem[i] = 16'(i) ^ 16'h5A5A;
      mmem[i] = 16'(i) ^ 16'h5A5A;
    end
    rmem[16] = 16'hBEEF;
    mmem[16] = 16'hBEEF;
  end
  always @(posedge clk) begin
    if (mem_we) rmem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= rmem[mem_addr[9:0]];
  end

  typedef struct {
    logic        is_ma;
    logic        chk;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int n_pass = 0, n_total = 0;
  owner_t tb_last = OWN_IF;
  logic [15:0] exp_wdata = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_rvalid || ma_rvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_rvalid", {30'd0, if_rvalid, ma_rvalid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("rvalid_owner", {30'd0, if_rvalid, ma_rvalid}, e.is_ma ? 32'd1 : 32'd2);
          check("rvalid_cycle", cyc, e.due);
          if (e.chk) check("rdata", e.is_ma ? ma_rdata : if_rdata, e.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("missing_rvalid", {30'd0, if_rvalid, ma_rvalid}, e.is_ma ? 32'd1 : 32'd2);
      end
    end
  end

  task automatic drive(input logic ifr, input logic [15:0] ifa, input logic mar,
                       input logic mwe, input logic [15:0] maa, input logic [15:0] mwd);
    @(posedge clk); #1;
    if_req = ifr; if_addr = ifa; ma_req = mar; ma_we = mwe; ma_addr = maa; ma_wdata = mwd;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic expect_grant(input logic is_ma, input logic we, input logic [15:0] addr,
                              input logic [15:0] wd);
    exp_t e;
    e.is_ma = is_ma;
    e.due   = cyc + 2;
    e.chk   = !(is_ma && we);
    if (is_ma && we) mmem[addr[9:0]] = wd;
    e.data  = mmem[addr[9:0]];
    sb.push_back(e);
    tb_last = is_ma ? OWN_MA : OWN_IF;
    if (is_ma) exp_wdata = wd;
  endtask

  function automatic logic tie_to_ma();
`ifdef ARB_ROUND_ROBIN_EN
    return tb_last == OWN_IF;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b1; ma_req = 1'b1; sb.delete();
    #2;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_ma_gnt", ma_gnt, 0);
    @(posedge clk); #3;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rvalid", {if_rvalid, ma_rvalid}, 0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; ma_req = 1'b0;
    tb_last = OWN_IF; exp_wdata = '0;
    #2;
  endtask

  typedef struct {
    logic        ifr;
    logic [15:0] ifa;
    logic        mar;
    logic        mwe;
    logic [15:0] maa;
    logic [15:0] mwd;
    logic [1:0]  win;  // 0 none, 1 IF, 2 MA, 3 tie
  } vec_t;
  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g_if, g_ma, mwe_v;
    vt[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1};
    vt[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0200, 16'h1234, 2'd2};
    vt[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'd2};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0};
    vt[4] = '{1'b1, 16'h0044, 1'b1, 1'b0, 16'h0010, 16'h0055, 2'd3};
    vt[5] = '{1'b1, 16'h0200, 1'b1, 1'b1, 16'h0123, 16'hCAFE, 2'd3};
    vt[6] = '{1'b1, 16'h0123, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd1};
    vt[7] = '{1'b1, 16'h0300, 1'b1, 1'b0, 16'h0044, 16'h0066, 2'd3};

    do_reset();

    // table: each request lands in IDLE or in the previous access's RESP
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].ifr, vt[i].ifa, vt[i].mar, vt[i].mwe, vt[i].maa, vt[i].mwd);
      check($sformatf("vec%0d_mem_we_off", i), mem_we, 0);
      g_ma = (vt[i].win == 2'd2) || (vt[i].win == 2'd3 && tie_to_ma());
      g_if = (vt[i].win == 2'd1) || (vt[i].win == 2'd3 && !g_ma);
      check($sformatf("vec%0d_gnt", i), {if_gnt, ma_gnt}, {g_if, g_ma});
      check($sformatf("vec%0d_stall", i), stall_if, vt[i].ifr & ~g_if);
      if (g_if) expect_grant(1'b0, 1'b0, vt[i].ifa, 16'h0);
      if (g_ma) expect_grant(1'b1, vt[i].mwe, vt[i].maa, vt[i].mwd);
      mwe_v = g_ma & vt[i].mwe;
      idle();
      if (g_if || g_ma) begin
        check($sformatf("vec%0d_mem_addr", i), mem_addr, g_ma ? vt[i].maa : vt[i].ifa);
        check($sformatf("vec%0d_mem_we", i), mem_we, mwe_v);
        check($sformatf("vec%0d_mem_wdata", i), mem_wdata, exp_wdata);
      end
    end
    idle(); idle();

    // both requesting continuously
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0300, 16'h0000);
      if (k % 2 == 0) begin
        g_ma = tie_to_ma();
        g_if = !g_ma;
        check($sformatf("cont%0d_gnt", k), {if_gnt, ma_gnt}, {g_if, g_ma});
        check($sformatf("cont%0d_stall", k), stall_if, !g_if);
        if (g_if) expect_grant(1'b0, 1'b0, 16'h0010, 16'h0);
        else expect_grant(1'b1, 1'b0, 16'h0300, 16'h0000);
      end else begin
        check($sformatf("cont%0d_gnt", k), {if_gnt, ma_gnt}, 0);
        check($sformatf("cont%0d_stall", k), stall_if, 1);
        check($sformatf("cont%0d_mem_we", k), mem_we, 0);
      end
    end
    idle(); idle(); idle();

    // a request raised during ACCESS and dropped before any grant is ignored
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0044, 16'h0000);
    check("drop_ma_gnt", ma_gnt, 1);
    expect_grant(1'b1, 1'b0, 16'h0044, 16'h0000);
    drive(1'b1, 16'h0123, 1'b0, 1'b0, 16'h0, 16'h0);
    check("drop_access_gnt", {if_gnt, ma_gnt}, 0);
    check("drop_access_stall", stall_if, 1);
    idle();
    check("drop_resp_gnt", {if_gnt, ma_gnt}, 0);
    idle();
    check("drop_state_idle", 32'(dut.r_state), 32'(IDLE));
    check("drop_addr_hold", mem_addr, 16'h0044);
    idle();

    // reset during ACCESS of an MA write aborts it
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h7777);
    check("rstacc_ma_gnt", ma_gnt, 1);
    @(posedge clk); #1;
    rst = 1'b1; ma_req = 1'b0; ma_we = 1'b0;
    #2;
    check("rstacc_we_in_access", mem_we, 1);
    check("rstacc_gnt_in_rst", {if_gnt, ma_gnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0; tb_last = OWN_IF; exp_wdata = '0;
    ma_req = 1'b1; ma_we = 1'b0; ma_addr = 16'h0010;
    #2;
    check("rstacc_mem_we", mem_we, 0);
    check("rstacc_state", 32'(dut.r_state), 32'(IDLE));
    check("rstacc_no_rvalid", ma_rvalid, 0);
    check("rstacc_regrant", ma_gnt, 1);
    expect_grant(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle();
    check("rstacc_mem_addr", mem_addr, 16'h0010);
    check("rstacc_mem_we2", mem_we, 0);
    idle(); idle(); idle();

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Ports (clock and reset first), one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch stage read request, held until granted.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- ma_req  in  1  memory-access stage request, held until granted.
- ma_we  in  1  1 = write, 0 = read.
- ma_addr  in  ADDR_W  MA address.
- ma_wdata  in  DATA_W  MA write data.
- ma_gnt  out  1  MA request accepted this cycle.
- ma_rvalid  out  1  MA read data valid, or write done.
- ma_rdata  out  DATA_W  MA read data.
- mem_addr  out  ADDR_W  shared memory address, registered.
- mem_wdata  out  DATA_W  shared memory write data, registered.
- mem_we  out  1  shared memory write enable, registered.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr.
- stall_if  out  1  if_req & ~if_gnt; freezes the fetch PC.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-005 In IDLE or RESP with any request present, the block SHALL assert exactly one gnt (combinational) and move to ACCESS. With no request, it SHALL go to IDLE.
REQ-006 On the grant edge, mem_addr, mem_wdata and mem_we SHALL load from the winner; for an IF grant, mem_we=0 and mem_wdata holds its previous value.
REQ-007 ACCESS SHALL last exactly one cycle and then go to RESP unconditionally. No gnt is asserted in ACCESS.
REQ-008 mem_we SHALL be 1 only during the ACCESS cycle of an MA write; in every other state it is 0.
REQ-009 In RESP, the owner's rvalid SHALL be 1 for exactly one cycle. The owner's rdata SHALL equal mem_rdata, and the other rvalid SHALL be 0.
REQ-010 Latency SHALL be: gnt in cycle N, memory address in N+1, rvalid in N+2. A new grant may coincide with RESP, giving a peak rate of one access per 2 cycles.
REQ-011 When both requesters ask in the same cycle, MA SHALL win (see REQ-016).
REQ-012 mem_addr SHALL hold its last value outside ACCESS.
REQ-013 A requester deasserting req before its gnt SHALL be ignored, with no access made.

Reset
REQ-014 On rst=1 at a clock edge, the block SHALL force state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, all gnt/rvalid=0, and last_owner=IF.
REQ-015 Reset in ACCESS or RESP SHALL abort the access: no rvalid for it afterwards and no write repeated. gnt SHALL be 0 during any cycle with rst=1.

Configuration
REQ-016 Macro ARB_ROUND_ROBIN_EN:
- Defined: a last_owner flop SHALL be kept, and a simultaneous request SHALL go to the requester not granted last.
- Undefined: fixed MA priority applies and no last_owner flop is built.

Structure
REQ-017 A shared package SHALL hold the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_IF/OWN_MA) and the ADDR_W/DATA_W defaults.
REQ-018 The priority decision SHALL sit in one sub-module, arb_pick: inputs if_req, ma_req, last_owner; outputs the winner owner.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- IF only, if_addr=0x0010, mem returns 0xBEEF: if_gnt at N, mem_addr=0x0010 at N+1, if_rvalid=1 with if_rdata=0xBEEF at N+2.
- MA write addr=0x0200, wdata=0x1234: ma_gnt at N, mem_we=1 only at N+1 with mem_addr=0x0200/mem_wdata=0x1234, ma_rvalid at N+2.
- Both requesting continuously without the macro: MA granted every 2 cycles; stall_if=1 throughout and if_gnt never asserted.
- Both requesting continuously with ARB_ROUND_ROBIN_EN: grants alternate MA, IF, MA, IF at cycles 0, 2, 4, 6.
- rst asserted during ACCESS of an MA write: next cycle mem_we=0, state IDLE, no ma_rvalid, and a new request is granted the cycle after rst falls.
